// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, prescale counter width and bit-period reload values.
// Pure declarations; no latency or backpressure.
package uart_pkg;

    localparam int C_CNT_W = 19;
    localparam int C_BIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // The counter counts down to zero inclusive, so a period of N cycles reloads N-1.
    function automatic logic [C_CNT_W-1:0] f_reload(input int prescale, input logic half);
        logic [C_CNT_W-1:0] v_p;
        v_p = C_CNT_W'(prescale);
        return half ? (v_p << 2) - C_CNT_W'(1) : (v_p << 3) - C_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input, reset to 1 (idle line); 2-cycle latency.
// No backpressure.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing with mid-bit sampling; word valid one cycle after the stop-bit sample.
// Held word waits on uart_rxready; a newer word overwrites it and pulses overrun_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int G_DATAWIDTH = 8,
    parameter int G_PRESCALE  = 1302
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    output logic [G_DATAWIDTH-1:0] uart_rxdata,
    output logic                   uart_rxvalid,
    input  logic                   uart_rxready,
    output logic                   busy,
    output logic                   frame_error,
    output logic                   overrun_error
);

    localparam logic [C_CNT_W-1:0] C_FULL = f_reload(G_PRESCALE, 1'b0);
    localparam logic [C_CNT_W-1:0] C_HALF = f_reload(G_PRESCALE, 1'b1);

    logic                   w_rxd_s;
    logic                   w_tick;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_CNT_W-1:0]     w_cnt_nxt;
    logic [C_BIT_W-1:0]     r_bits;
    logic [C_BIT_W-1:0]     w_bits_nxt;
    logic [G_DATAWIDTH-1:0] r_shift;
    logic [G_DATAWIDTH-1:0] w_shift_nxt;
    logic                   w_done;
    logic                   w_ferr;
    logic [G_DATAWIDTH-1:0] r_data;
    logic                   r_vld;
    logic                   r_ferr;
    logic                   r_ovr;

    uart_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rxd),
        .o_sync  (w_rxd_s)
    );

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? r_cnt : r_cnt - C_CNT_W'(1);
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_cnt_nxt   = C_HALF;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (!w_rxd_s) begin
                        w_cnt_nxt   = C_FULL;
                        w_bits_nxt  = C_BIT_W'(G_DATAWIDTH);
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    // LSB arrives first, so each bit enters at the top and walks down.
                    w_shift_nxt                  = r_shift >> 1;
                    w_shift_nxt[G_DATAWIDTH-1]   = w_rxd_s;
                    w_bits_nxt                   = r_bits - C_BIT_W'(1);
                    w_cnt_nxt                    = C_FULL;
                    if (r_bits == C_BIT_W'(1)) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (w_rxd_s) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_shift <= w_shift_nxt;
            r_ferr  <= w_ferr;
            r_ovr   <= w_done & r_vld & ~uart_rxready;
            if (w_done) begin
                r_data <= r_shift;
                r_vld  <= 1'b1;
            end else if (uart_rxready) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign uart_rxdata   = r_data;
    assign uart_rxvalid  = r_vld;
    assign busy          = (r_state != IDLE);
    assign frame_error   = r_ferr;
    assign overrun_error = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with G_PRESCALE=4 (32-cycle bit period), 8 data bits.
module tb_uart_rx;

    localparam int P = 4;
    localparam int N = 8;
    localparam int BIT = P * 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rxd = 1'b1;
    logic         uart_rxready = 1'b0;
    logic [N-1:0] uart_rxdata;
    logic         uart_rxvalid;
    logic         busy;
    logic         frame_error;
    logic         overrun_error;

    int n_vec = 0;
    int n_bad = 0;

    uart_rx #(.G_DATAWIDTH(N), .G_PRESCALE(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .uart_rxdata   (uart_rxdata),
        .uart_rxvalid  (uart_rxvalid),
        .uart_rxready  (uart_rxready),
        .busy          (busy),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    // Monitor: counts events on the falling edge, away from the active edge.
    logic [N-1:0] rx_data [0:511];
    int   ncyc = 0, rx_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, busy_cyc = 0, vld_cyc = 0;
    int   t_fall = 0, t_rise = 0;
    logic rxd_prev = 1'b1, vld_prev = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            if (uart_rxvalid && uart_rxready && rx_cnt < 512) begin
                rx_data[rx_cnt] = uart_rxdata;
                rx_cnt++;
            end
            if (frame_error)   ferr_cnt++;
            if (overrun_error) ovr_cnt++;
            if (busy)          busy_cyc++;
            if (uart_rxvalid)  vld_cyc++;
            if (rxd_prev && !rxd && !busy) t_fall = ncyc;
            if (uart_rxvalid && !vld_prev) t_rise = ncyc;
        end
        rxd_prev = rxd;
        vld_prev = uart_rxvalid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop);
        logic [N+1:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < N + 2; i++) begin
            rxd = f[i];
            tick(BIT);
        end
    endtask

    int rx0, ferr0, ovr0, busy0, vld0;
    logic [N-1:0] exp_w [0:127];
    logic [N+1:0] part;

    task automatic snap();
        rx0 = rx_cnt; ferr0 = ferr_cnt; ovr0 = ovr_cnt; busy0 = busy_cyc; vld0 = vld_cyc;
    endtask

    initial begin
        tick(4);
        settle();
        check("rst_data",  32'(uart_rxdata), 32'h0);
        check("rst_valid", 32'(uart_rxvalid), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_ferr",  32'(frame_error), 32'h0);
        check("rst_ovr",   32'(overrun_error), 32'h0);
        tick(1);
        rst = 1'b1;
        tick(5);

        // single frame, consumer always ready
        uart_rxready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        tick(20);
        settle();
        check("a5_count",   32'(rx_cnt - rx0), 32'd1);
        check("a5_data",    32'(rx_data[rx0]), 32'hA5);
        check("a5_vldlen",  32'(vld_cyc - vld0), 32'd1);
        check("a5_latency", 32'(t_rise - t_fall), 32'(2 + (P << 2) + (N + 1) * (P << 3) + 1));
        check("a5_ferr",    32'(ferr_cnt - ferr0), 32'd0);
        check("a5_busy",    32'(busy), 32'h0);

        // back-to-back frames
        tick(1);
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        settle();
        check("b2b_count", 32'(rx_cnt - rx0), 32'd2);
        check("b2b_d0",    32'(rx_data[rx0]), 32'h00);
        check("b2b_d1",    32'(rx_data[rx0 + 1]), 32'hFF);
        check("b2b_errs",  32'((ferr_cnt - ferr0) + (ovr_cnt - ovr0)), 32'd0);

        // false start: 8-cycle glitch
        tick(1);
        snap();
        rxd = 1'b0;
        tick(8);
        rxd = 1'b1;
        tick(40);
        settle();
        check("glitch_count", 32'(rx_cnt - rx0), 32'd0);
        check("glitch_busy",  32'(busy_cyc - busy0), 32'd16);
        check("glitch_idle",  32'(busy), 32'h0);

        // framing error then line held low
        tick(1);
        snap();
        send_frame(8'h3C, 1'b0);
        tick(100);
        settle();
        check("ferr_pulse", 32'(ferr_cnt - ferr0), 32'd1);
        check("ferr_novld", 32'(vld_cyc - vld0), 32'd0);
        check("ferr_busy",  32'(busy), 32'h1);
        tick(1);
        rxd = 1'b1;
        tick(10);
        settle();
        check("ferr_release", 32'(busy), 32'h0);

        // overrun with consumer stalled
        tick(1);
        uart_rxready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        settle();
        check("ovr_v1",    32'(uart_rxvalid), 32'h1);
        check("ovr_d1",    32'(uart_rxdata), 32'h11);
        tick(1);
        send_frame(8'h22, 1'b1);
        settle();
        check("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_d2",    32'(uart_rxdata), 32'h22);
        check("ovr_v2",    32'(uart_rxvalid), 32'h1);
        check("ovr_noxfer", 32'(rx_cnt - rx0), 32'd0);
        tick(1);
        uart_rxready = 1'b1;
        tick(1);
        uart_rxready = 1'b0;
        settle();
        check("ovr_clear", 32'(uart_rxvalid), 32'h0);
        check("ovr_xfer",  32'(rx_data[rx0]), 32'h22);

        // reset during data bit 4 while a word is still held
        tick(1);
        send_frame(8'h77, 1'b1);
        part = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxd = part[i];
            tick(BIT);
        end
        rxd = part[5];
        tick(16);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        rxd = 1'b1;
        settle();
        check("mrst_data",  32'(uart_rxdata), 32'h0);
        check("mrst_valid", 32'(uart_rxvalid), 32'h0);
        check("mrst_busy",  32'(busy), 32'h0);
        check("mrst_errs",  32'({frame_error, overrun_error}), 32'h0);
        snap();
        tick(300);
        settle();
        check("mrst_quiet", 32'(vld_cyc - vld0), 32'd0);
        tick(1);
        uart_rxready = 1'b1;
        snap();
        send_frame(8'h5A, 1'b1);
        tick(20);
        settle();
        check("mrst_count", 32'(rx_cnt - rx0), 32'd1);
        check("mrst_5a",    32'(rx_data[rx0]), 32'h5A);

        // stream of random words, back to back
        tick(1);
        snap();
        for (int i = 0; i < 128; i++) begin
            exp_w[i] = N'($urandom);
            send_frame(exp_w[i], 1'b1);
        end
        tick(20);
        settle();
        check("rand_count", 32'(rx_cnt - rx0), 32'd128);
        check("rand_errs",  32'((ferr_cnt - ferr0) + (ovr_cnt - ovr0)), 32'd0);
        for (int i = 0; i < 128; i++) begin
            check($sformatf("rand_w%0d", i), 32'(rx_data[rx0 + i]), 32'(exp_w[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
